// File: rtl/multi_cycle_core_if.sv
// Memory bus between multi_cycle_core and its instruction/data memory.
//   mem_req   : transaction request (core -> memory)
//   mem_we    : 1 = store, 0 = fetch/load
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_rdata : read data, valid while mem_req && mem_ready
//   mem_ready : completes the transaction in any cycle with mem_req high
interface multi_cycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I/RV32E subset core (lw, sw, ALU immediate and register ops).
// One instruction at a time through FETCH, DECODE, EXEC, MEM, WB; exceptions halt.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus        : memory bus (master side), shared by fetch and data access
//   pc_o       : current PC (already advanced past the fetched instruction)
//   retire     : one-cycle pulse per completed instruction
//   trap       : core halted on exception, sticky until reset
//   trap_cause : 01 illegal instruction, 10 misaligned data address, 00 none
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  multi_cycle_core_if.master        bus,
  output logic [31:0]               pc_o,
  output logic                      retire,
  output logic                      trap,
  output logic [1:0]                trap_cause
);

  localparam int unsigned RW = (NUM_REGS == 16) ? 4 : 5;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
  logic [1:0]  cause_q;
  logic [31:0] regs_q [NUM_REGS];

  // Decode fields, valid from DECODE onwards for the instruction in IR.
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_load, is_store, is_opimm, is_op, uses_rd, uses_rs2, bad_reg, illegal;
  assign is_load  = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_store = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_opimm = (opcode == 7'b0010011) &&
                    (funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
  assign is_op    = (opcode == 7'b0110011) &&
                    (((funct7 == 7'b0000000) &&
                      (funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111})) ||
                     ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
  assign uses_rd  = is_load | is_opimm | is_op;
  assign uses_rs2 = is_store | is_op;
  // RV32E: only the register fields the instruction actually uses are checked.
  assign bad_reg  = (NUM_REGS == 16) &&
                    (rs1[4] || (uses_rs2 && rs2[4]) || (uses_rd && rd[4]));
  assign illegal  = !(is_load | is_store | is_opimm | is_op) || bad_reg;

  logic [31:0] rs1_val, rs2_val, imm_d;
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs_q[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs_q[rs2[RW-1:0]];
  assign imm_d   = is_store ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]}
                            : {{20{ir_q[31]}}, ir_q[31:20]};

  logic [31:0] op_b, alu_res;
  logic        misaligned;
  assign op_b = is_op ? b_q : imm_q;

  // Loads and stores fall through to the default add for address generation.
  always_comb begin
    alu_res = a_q + op_b;
    if (is_op || is_opimm) begin
      case (funct3)
        3'b000:  alu_res = (is_op && funct7[5]) ? a_q - op_b : a_q + op_b;
        3'b010:  alu_res = {31'd0, $signed(a_q) < $signed(op_b)};
        3'b100:  alu_res = a_q ^ op_b;
        3'b110:  alu_res = a_q | op_b;
        3'b111:  alu_res = a_q & op_b;
        default: alu_res = a_q + op_b;
      endcase
    end
  end

  assign misaligned = (is_load || is_store) && (alu_res[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = pc_q;
    bus.mem_wdata = b_q;
    retire        = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: state_d = illegal ? HALT : EXEC;
      EXEC: begin
        if (misaligned)                state_d = HALT;
        else if (is_load || is_store)  state_d = MEM;
        else                           state_d = WB;
      end
      MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = alu_q;
        bus.mem_we   = is_store;
        if (bus.mem_ready) begin
          retire  = is_store;
          state_d = is_store ? FETCH : WB;
        end
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
    // Reset state is FETCH, so the request must be masked while rst is low.
    if (!rst) bus.mem_req = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      cause_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i[RW-1:0]] <= '0;
    end else begin
      case (state_q)
        FETCH: if (bus.mem_ready) begin
          ir_q <= bus.mem_rdata;
          pc_q <= pc_q + 32'd4;
        end
        DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          imm_q <= imm_d;
          if (illegal) cause_q <= 2'b01;
        end
        EXEC: begin
          alu_q <= alu_res;
          if (misaligned) cause_q <= 2'b10;
        end
        MEM: if (bus.mem_ready && is_load) mdr_q <= bus.mem_rdata;
        WB: if (uses_rd && (rd != 5'd0)) regs_q[rd[RW-1:0]] <= is_load ? mdr_q : alu_q;
        default: ;
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign trap       = (state_q == HALT);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: directed programs, scoreboarded stores and retire timing.
module tb_multi_cycle_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_core_if mif();
  multi_cycle_core_if mif16();

  logic [31:0] pc, pc16;
  logic        ret, ret16, trp, trp16;
  logic [1:0]  cause, cause16;

  multi_cycle_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .bus(mif.master),
    .pc_o(pc), .retire(ret), .trap(trp), .trap_cause(cause));

  multi_cycle_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .bus(mif16.master),
    .pc_o(pc16), .retire(ret16), .trap(trp16), .trap_cause(cause16));

  logic [31:0] mem [256];
  assign mif.mem_rdata   = mem[mif.mem_addr[9:2]];
  assign mif16.mem_rdata = 32'h0010_0893;   // addi x17,x0,1
  assign mif16.mem_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_f = 0;
  int stall_d = 0;
  logic req_after_trap = 1'b0;
  logic ret16_seen = 1'b0;

  int          exp_ret[$];
  logic [31:0] exp_st_addr[$];
  logic [31:0] exp_st_data[$];

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
    exp_st_addr.push_back(a);
    exp_st_data.push_back(d);
  endtask

  // Memory ready model: stalls each transaction by stall_f (fetch) or stall_d (data) cycles.
  int   wcnt = 0;
  logic done_prev = 1'b0;
  initial forever begin
    int lim;
    @(negedge clk);
    if (!rst || done_prev || !mif.mem_req) wcnt = 0;
    lim = (mif.mem_addr >= 32'h100) ? stall_d : stall_f;
    if (mif.mem_req && wcnt < lim) begin
      mif.mem_ready = 1'b0;
      wcnt++;
    end else begin
      mif.mem_ready = 1'b1;
    end
    done_prev = mif.mem_req && mif.mem_ready;
  end

  initial forever begin
    @(posedge clk);
    if (!rst) cyc = 0;
    else      cyc++;
  end

  // Monitor: bus stability, store scoreboard, retire-cycle scoreboard.
  logic        have_prev = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check("bus_stable_addr", mif.mem_addr, prev_addr);
        check("bus_stable_we", 32'(mif.mem_we), 32'(prev_we));
        check("bus_stable_wdata", mif.mem_wdata, prev_wdata);
      end
      have_prev  = mif.mem_req && !mif.mem_ready;
      prev_addr  = mif.mem_addr;
      prev_we    = mif.mem_we;
      prev_wdata = mif.mem_wdata;
      if (mif.mem_req && mif.mem_ready && mif.mem_we) begin
        if (exp_st_addr.size() == 0) begin
          check("unexpected_store_addr", mif.mem_addr, 32'hFFFF_FFFF);
        end else begin
          check("store_addr", mif.mem_addr, exp_st_addr.pop_front());
          check("store_data", mif.mem_wdata, exp_st_data.pop_front());
        end
      end
      if (ret) begin
        if (exp_ret.size() == 0) check("unexpected_retire_cycle", 32'(cyc + 1), 32'hFFFF_FFFF);
        else                     check("retire_cycle", 32'(cyc + 1), 32'(exp_ret.pop_front()));
      end
      if (trp && mif.mem_req) req_after_trap = 1'b1;
      if (ret16) ret16_seen = 1'b1;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 req_after_trap = 1'b0;
  endtask

  task automatic start();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #2;
    check("first_req", 32'(mif.mem_req), 32'd1);
    check("first_addr", mif.mem_addr, 32'h0);
    check("first_we", 32'(mif.mem_we), 32'd0);
  endtask

  task automatic run_to_trap(input int budget, input logic [1:0] exp_cause,
                             input logic [31:0] exp_pc);
    int n = 0;
    while (!trp && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    #2;
    check("trap", 32'(trp), 32'd1);
    check("trap_cause", 32'(cause), 32'(exp_cause));
    check("halt_pc", pc, exp_pc);
    check("req_after_trap", 32'(req_after_trap), 32'd0);
    check("retires_pending", 32'(exp_ret.size()), 32'd0);
    check("stores_pending", 32'(exp_st_addr.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Program A: ALU ops and x1/x2 arithmetic, results stored for checking.
    clear_mem();
    mem[0]  = 32'h0050_0093;                                // addi x1,x0,5
    mem[1]  = enc_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'h13);   // addi x2,x1,-7
    mem[2]  = enc_s(5'd1, 5'd0, 12'h180);
    mem[3]  = enc_s(5'd2, 5'd0, 12'h184);
    mem[4]  = enc_i(12'h000, 5'd2, 3'b010, 5'd5, 7'h13);   // slti x5,x2,0
    mem[5]  = enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd6);      // sub x6,x0,x1
    mem[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7);      // slt x7,x1,x2
    mem[7]  = enc_i(12'h0F0, 5'd1, 3'b100, 5'd8, 7'h13);   // xori x8,x1,0xF0
    mem[8]  = enc_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd9);      // and x9,x2,x1
    mem[9]  = enc_s(5'd5, 5'd0, 12'h188);
    mem[10] = enc_s(5'd6, 5'd0, 12'h18C);
    mem[11] = enc_s(5'd7, 5'd0, 12'h190);
    mem[12] = enc_s(5'd8, 5'd0, 12'h194);
    mem[13] = enc_s(5'd9, 5'd0, 12'h198);
    mem[14] = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(mif.mem_req), 32'd0);
    check("rst_retire", 32'(ret), 32'd0);
    check("rst_trap", 32'(trp), 32'd0);
    check("rst_cause", 32'(cause), 32'd0);
    check("rst_pc", pc, 32'h0);
    for (int i = 1; i <= 14; i++) exp_ret.push_back(4 * i);
    expect_store(32'h180, 32'h0000_0005);
    expect_store(32'h184, 32'hFFFF_FFFE);
    expect_store(32'h188, 32'h0000_0001);
    expect_store(32'h18C, 32'hFFFF_FFFB);
    expect_store(32'h190, 32'h0000_0000);
    expect_store(32'h194, 32'h0000_00F5);
    expect_store(32'h198, 32'h0000_0004);
    start();
    run_to_trap(200, 2'b01, 32'h3C);
    check("rv32e_trap", 32'(trp16), 32'd1);
    check("rv32e_cause", 32'(cause16), 32'd1);
    check("rv32e_no_retire", 32'(ret16_seen), 32'd0);
    check("rv32e_pc", pc16, 32'h4);

    // Program B: lw/sw, then misaligned lw.
    do_reset();
    clear_mem();
    mem[64] = 32'hDEAD_BEEF;
    mem[0]  = enc_i(12'h100, 5'd0, 3'b010, 5'd3, 7'h03);   // lw x3,0x100(x0)
    mem[1]  = enc_s(5'd3, 5'd0, 12'h104);
    mem[2]  = enc_i(12'h002, 5'd0, 3'b010, 5'd1, 7'h03);   // lw x1,2(x0)
    exp_ret.push_back(5);
    exp_ret.push_back(9);
    expect_store(32'h104, 32'hDEAD_BEEF);
    start();
    run_to_trap(100, 2'b10, 32'h0C);

    // Program C: same load/store with 3 wait cycles on every transaction.
    do_reset();
    clear_mem();
    stall_f = 3;
    stall_d = 3;
    mem[64] = 32'hDEAD_BEEF;
    mem[0]  = enc_i(12'h100, 5'd0, 3'b010, 5'd3, 7'h03);
    mem[1]  = enc_s(5'd3, 5'd0, 12'h108);
    mem[2]  = 32'hFFFF_FFFF;
    exp_ret.push_back(11);
    exp_ret.push_back(21);
    expect_store(32'h108, 32'hDEAD_BEEF);
    start();
    run_to_trap(200, 2'b01, 32'h0C);
    stall_f = 0;
    stall_d = 0;

    // Program D: x0 semantics, then slli (unsupported) traps as illegal.
    do_reset();
    clear_mem();
    mem[0] = enc_i(12'h009, 5'd0, 3'b000, 5'd0, 7'h13);    // addi x0,x0,9
    mem[1] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd4);       // add x4,x0,x0
    mem[2] = enc_s(5'd4, 5'd0, 12'h1A0);
    mem[3] = enc_s(5'd0, 5'd0, 12'h1A4);
    mem[4] = enc_i(12'h001, 5'd1, 3'b001, 5'd1, 7'h13);    // slli x1,x1,1
    for (int i = 1; i <= 4; i++) exp_ret.push_back(4 * i);
    expect_store(32'h1A0, 32'h0);
    expect_store(32'h1A4, 32'h0);
    start();
    run_to_trap(100, 2'b01, 32'h14);

    // Program E: reset while a stalled store is pending.
    do_reset();
    clear_mem();
    stall_d = 1000;
    mem[0] = enc_i(12'h007, 5'd0, 3'b000, 5'd1, 7'h13);    // addi x1,x0,7
    mem[1] = enc_s(5'd1, 5'd0, 12'h1B0);
    exp_ret.push_back(4);
    start();
    while (cyc < 11) @(posedge clk);
    #1;
    check("pend_store_req", 32'(mif.mem_req), 32'd1);
    check("pend_store_we", 32'(mif.mem_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_req", 32'(mif.mem_req), 32'd0);
    check("abort_pc", pc, 32'h0);
    check("abort_retire", 32'(ret), 32'd0);
    check("abort_pending_retires", 32'(exp_ret.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 req_after_trap = 1'b0;
    stall_d = 0;
    mem[0] = enc_s(5'd1, 5'd0, 12'h1B4);                   // x1 must read back as 0
    mem[1] = 32'hFFFF_FFFF;
    exp_ret.push_back(4);
    expect_store(32'h1B4, 32'h0);
    start();
    run_to_trap(100, 2'b01, 32'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter NUM_REGS, default 32, register count; legal values 32 (RV32I) or 16 (RV32E).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = store, 0 = fetch/load.
REQ-007 mem_addr  output  32  word-aligned byte address.
REQ-008 mem_wdata  output  32  store data.
REQ-009 mem_rdata  input  32  read data, valid in the cycle mem_req && mem_ready.
REQ-010 mem_ready  input  1  transaction completes in any cycle where mem_req && mem_ready.
REQ-011 pc_o  output  32  current PC.
REQ-012 retire  output  1  one-cycle pulse per completed instruction.
REQ-013 trap  output  1  core halted on exception; sticky until reset.
REQ-014 trap_cause  output  2  01 illegal instruction, 10 misaligned data address, 00 none.

Function
REQ-015 Supported: lw, sw (funct3 010); addi/slti/xori/ori/andi (opcode 0010011); add/sub/slt/xor/or/and (opcode 0110011, funct7 0000000, or 0100000 for sub only); all other encodings illegal.
REQ-016 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; reset state FETCH.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on handshake latch IR=mem_rdata, PC<=PC+4, go DECODE; else hold.
REQ-018 DECODE: read rs1/rs2 into A/B latches, sign-extend I-imm (IR[31:20]) or S-imm ({IR[31:25],IR[11:7]}); illegal encoding -> HALT, trap_cause=01.
REQ-019 EXEC: ALUOut <= A op (B or imm); lw/sw with ALUOut[1:0]!=0 -> HALT, trap_cause=10; lw/sw -> MEM; ALU ops -> WB.
REQ-020 MEM: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw with mem_wdata=B; hold until handshake; sw -> FETCH with retire; lw latches MDR=mem_rdata -> WB.
REQ-021 WB: rd <= ALUOut (ALU op) or MDR (lw); retire=1; -> FETCH.
REQ-022 Latency with mem_ready tied high: ALU op 4 cycles, sw 4 cycles, lw 5 cycles; each wait cycle adds 1.
REQ-023 mem_addr, mem_we, mem_wdata SHALL remain stable while mem_req=1 and mem_ready=0.
REQ-024 mem_req=0 in DECODE, EXEC, WB, HALT.
REQ-025 Writes to x0 discarded; reads of x0 return 0.
REQ-026 NUM_REGS=16: any rs1/rs2/rd field with bit 4 set is illegal (trap_cause=01).
REQ-027 slt/slti signed compare; sub two's complement, 32-bit wrap, no overflow flag; PC+4 wraps at 2^32.
REQ-028 HALT: no memory requests, no register writes, pc_o frozen at PC of the following instruction, trap=1.
REQ-029 Trapped instruction SHALL NOT retire or write rd.

Reset
REQ-030 rst low SHALL immediately force: state FETCH, PC=RESET_PC, all registers 0, IR/A/B/ALUOut/MDR 0, mem_req=0 while asserted, retire=0, trap=0, trap_cause=00.
REQ-031 Reset asserted mid-transaction abandons the request; first request after release is a fetch at RESET_PC.
REQ-032 First fetch request SHALL appear in the first clk edge cycle after rst deasserts.

Verification
REQ-033 Memory {0x00: addi x1,x0,5 (0x00500093); 0x04: addi x2,x1,-7}, ready=1 -> x1=5, x2=0xFFFF_FFFE, retire pulses at cycles 4 and 8.
REQ-034 Word 0x100=0xDEAD_BEEF, lw x3,0x100(x0) -> x3=0xDEAD_BEEF after 5 cycles; sw x3,0x104(x0) -> write req addr 0x104 data 0xDEAD_BEEF, mem_we=1.
REQ-035 mem_ready held low 3 cycles during fetch and load -> mem_addr/mem_we stable, lw completes in 11 cycles, correct x3.
REQ-036 Instruction 0xFFFF_FFFF -> trap=1, trap_cause=01, no further mem_req, no retire; lw x1,2(x0) -> trap_cause=10.
REQ-037 addi x0,x0,9 then add x4,x0,x0 -> x4=0; NUM_REGS=16 with addi x17,x0,1 -> trap_cause=01.
REQ-038 rst pulsed low during MEM of a sw with mem_ready=0 -> mem_req drops immediately, registers 0, next request fetch at RESET_PC, no write issued.
